// File: rtl/fractcam_pkg.sv
// Shared FracTCAM definitions: slice geometry, update-engine states and the
// slice-count helper used by the update engine and the search-side array.
package fractcam_pkg;

  localparam int unsigned SLICE_WIDTH = 5;
  localparam int unsigned SLICE_ADDRS = 32;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DRAIN
  } state_e;

  function automatic int unsigned slices(input int unsigned width);
    return (width + SLICE_WIDTH - 1) / SLICE_WIDTH;
  endfunction

endpackage

// File: rtl/fractcam_update_if.sv
// Rule-request channel into the FracTCAM update engine (valid/ready handshake).
interface fractcam_update_if #(
  parameter int unsigned TCAM_WIDTH = 20,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned IDX_WIDTH  = $clog2(DEPTH)
);

  logic                  s_valid;
  logic                  s_ready;
  logic [IDX_WIDTH-1:0]  s_idx;
  logic [TCAM_WIDTH-1:0] s_key;
  logic [TCAM_WIDTH-1:0] s_mask;
  logic                  s_del;

  modport master (
    output s_valid, s_idx, s_key, s_mask, s_del,
    input  s_ready
  );

  modport slave (
    input  s_valid, s_idx, s_key, s_mask, s_del,
    output s_ready
  );

endinterface

// File: rtl/fractcam_slice_enc.sv
// One LUTRAM bit for one 5-bit slice column: set when the slice address matches
// the rule key on every cared-for bit, cleared for deleted entries.
module fractcam_slice_enc
  import fractcam_pkg::*;
(
  input  logic [SLICE_WIDTH-1:0] addr,
  input  logic [SLICE_WIDTH-1:0] key,
  input  logic [SLICE_WIDTH-1:0] mask,
  input  logic                   del,
  output logic                   wr_bit
);

  assign wr_bit = ~del & (((addr ^ key) & mask) == '0);

endmodule

// File: rtl/fractcam_update.sv
// FracTCAM write engine: expands one ternary rule into 32 LUTRAM column writes.
// Optional FRACTCAM_UPDATE_DONE_EN adds a done/done_idx completion pulse.
module fractcam_update
  import fractcam_pkg::*;
#(
  parameter int unsigned TCAM_WIDTH = 20,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned IDX_WIDTH  = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  fractcam_update_if.slave              req,
  output logic                          wr_en,
  output logic [4:0]                    wr_addr,
  output logic [slices(TCAM_WIDTH)-1:0] wr_data,
  output logic [DEPTH-1:0]              wr_sel,
  output logic                          search_block,
  output logic                          err
`ifdef FRACTCAM_UPDATE_DONE_EN
  ,
  output logic                          done,
  output logic [IDX_WIDTH-1:0]          done_idx
`endif
);

  localparam int unsigned SLICES    = slices(TCAM_WIDTH);
  localparam int unsigned PAD_WIDTH = SLICES * SLICE_WIDTH;
  localparam logic [4:0]  LAST_ADDR = 5'(SLICE_ADDRS - 1);

  state_e                state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [TCAM_WIDTH-1:0] key_q, key_d;
  logic [TCAM_WIDTH-1:0] mask_q, mask_d;
  logic                  del_q, del_d;
  logic                  wr_en_q, wr_en_d;
  logic [4:0]            wr_addr_q, wr_addr_d;
  logic [SLICES-1:0]     wr_data_q, wr_data_d;
  logic [DEPTH-1:0]      wr_sel_q, wr_sel_d;
  logic                  block_q, block_d;
  logic                  err_q, err_d;

  logic                  idx_ok;
  logic [4:0]            enc_addr;
  logic [PAD_WIDTH-1:0]  enc_key, enc_mask;
  logic                  enc_del;
  logic [SLICES-1:0]     enc_bits;

  assign req.s_ready = (state_q == IDLE);
  assign idx_ok      = 32'(req.s_idx) < DEPTH;

  // Encoders look one address ahead so every wr_* output comes straight from a flop.
  // Zero-extending the mask makes padding bits don't-care.
  always_comb begin
    if (state_q == IDLE) begin
      enc_addr = '0;
      enc_key  = PAD_WIDTH'(req.s_key);
      enc_mask = PAD_WIDTH'(req.s_mask);
      enc_del  = req.s_del;
    end else begin
      enc_addr = wr_addr_q + 5'd1;
      enc_key  = PAD_WIDTH'(key_q);
      enc_mask = PAD_WIDTH'(mask_q);
      enc_del  = del_q;
    end
  end

  for (genvar j = 0; j < SLICES; j++) begin : g_slice
    fractcam_slice_enc u_enc (
      .addr   (enc_addr),
      .key    (enc_key[j*SLICE_WIDTH +: SLICE_WIDTH]),
      .mask   (enc_mask[j*SLICE_WIDTH +: SLICE_WIDTH]),
      .del    (enc_del),
      .wr_bit (enc_bits[j])
    );
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    key_d     = key_q;
    mask_d    = mask_q;
    del_d     = del_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = '0;
    wr_sel_d  = '0;
    block_d   = block_q;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req.s_valid) begin
          if (idx_ok) begin
            state_d   = WRITE;
            idx_d     = req.s_idx;
            key_d     = req.s_key;
            mask_d    = req.s_mask;
            del_d     = req.s_del;
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = enc_bits;
            wr_sel_d  = DEPTH'(1) << req.s_idx;
            block_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WRITE: begin
        if (wr_addr_q == LAST_ADDR) begin
          state_d = DRAIN;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_q + 5'd1;
          wr_data_d = enc_bits;
          wr_sel_d  = DEPTH'(1) << idx_q;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        block_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      key_q     <= '0;
      mask_q    <= '0;
      del_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_sel_q  <= '0;
      block_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      key_q     <= key_d;
      mask_q    <= mask_d;
      del_q     <= del_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_sel_q  <= wr_sel_d;
      block_q   <= block_d;
      err_q     <= err_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign wr_sel       = wr_sel_q;
  assign search_block = block_q;
  assign err          = err_q;

`ifdef FRACTCAM_UPDATE_DONE_EN
  assign done     = (state_q == DRAIN);
  assign done_idx = idx_q;
`else
  // Without the done pulse, completion is visible as s_ready returning high.
`endif

endmodule

// File: tb/tb_fractcam_update.sv
// Scoreboard bench for fractcam_update: a 10-bit and a 7-bit (padded) instance.
module tb_fractcam_update;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic [4:0] addr;
    logic [1:0] data;
    logic [7:0] sel;
  } beat_t;

  beat_t       qa[$];
  beat_t       qb[$];
  beat_t       ea, eb;
  logic [31:0] seen0_a, seen1_a, seen0_b, seen1_b;

  logic       wra_en, wrb_en, blk_a, blk_b, err_a, err_b;
  logic [4:0] wra_addr, wrb_addr;
  logic [1:0] wra_data, wrb_data;
  logic [7:0] wra_sel, wrb_sel;

  fractcam_update_if #(.TCAM_WIDTH(10), .DEPTH(8), .IDX_WIDTH(4)) if_a ();
  fractcam_update_if #(.TCAM_WIDTH(7),  .DEPTH(8), .IDX_WIDTH(4)) if_b ();

`ifdef FRACTCAM_UPDATE_DONE_EN
  logic       done_a, done_b;
  logic [3:0] done_idx_a, done_idx_b;
`endif

  fractcam_update #(.TCAM_WIDTH(10), .DEPTH(8), .IDX_WIDTH(4)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .req          (if_a),
    .wr_en        (wra_en),
    .wr_addr      (wra_addr),
    .wr_data      (wra_data),
    .wr_sel       (wra_sel),
    .search_block (blk_a),
    .err          (err_a)
`ifdef FRACTCAM_UPDATE_DONE_EN
    ,
    .done         (done_a),
    .done_idx     (done_idx_a)
`endif
  );

  fractcam_update #(.TCAM_WIDTH(7), .DEPTH(8), .IDX_WIDTH(4)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .req          (if_b),
    .wr_en        (wrb_en),
    .wr_addr      (wrb_addr),
    .wr_data      (wrb_data),
    .wr_sel       (wrb_sel),
    .search_block (blk_b),
    .err          (err_b)
`ifdef FRACTCAM_UPDATE_DONE_EN
    ,
    .done         (done_b),
    .done_idx     (done_idx_b)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Per-bit ternary reference: any cared bit differing from its address bit kills the slice.
  function automatic logic [1:0] model(input int w, input logic [9:0] key, input logic [9:0] mask,
                                       input logic [4:0] addr, input logic del);
    logic [1:0] r;
    r = 2'b11;
    if (del) return 2'b00;
    for (int b = 0; b < w; b++) begin
      if (mask[b] && (key[b] != addr[b % 5])) r[b / 5] = 1'b0;
    end
    return r;
  endfunction

  task automatic push(input bit to_b, input int w, input logic [3:0] idx, input logic [9:0] key,
                      input logic [9:0] mask, input logic del);
    beat_t bt;
    for (int a = 0; a < 32; a++) begin
      bt.addr = 5'(a);
      bt.data = model(w, key, mask, 5'(a), del);
      bt.sel  = 8'h01 << idx;
      if (to_b) qb.push_back(bt);
      else      qa.push_back(bt);
    end
  endtask

  // Drive a request on A, wait for the handshake edge; returns in cycle T+1.
  task automatic send_a(input logic [3:0] idx, input logic [9:0] key, input logic [9:0] mask,
                        input logic del);
    if_a.s_idx   = idx;
    if_a.s_key   = key;
    if_a.s_mask  = mask;
    if_a.s_del   = del;
    if_a.s_valid = 1'b1;
    if (idx < 4'd8) push(1'b0, 10, idx, key, mask, del);
    @(posedge clk);
    #1;
  endtask

  task automatic observe_a(input int n, output logic [63:0] en, output logic [63:0] blk,
                           output logic [63:0] rdy);
    en  = '0;
    blk = '0;
    rdy = '0;
    for (int k = 1; k <= n; k++) begin
      en[k]  = wra_en;
      blk[k] = blk_a;
      rdy[k] = if_a.s_ready;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle_a(input int limit);
    int k;
    k = 0;
    while (if_a.s_ready !== 1'b1 && k < limit) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("a_idle_timeout", 64'(if_a.s_ready), 64'd1);
  endtask

  always @(negedge clk) begin
    if (wra_en === 1'b1) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_write addr=%0d data=%0h sel=%0h, no write expected",
                 wra_addr, wra_data, wra_sel);
      end else begin
        ea = qa.pop_front();
        chk("a_beat", 64'({wra_addr, wra_data, wra_sel}), 64'({ea.addr, ea.data, ea.sel}));
        seen0_a[wra_addr] = seen0_a[wra_addr] | wra_data[0];
        seen1_a[wra_addr] = seen1_a[wra_addr] | wra_data[1];
      end
    end
  end

  always @(negedge clk) begin
    if (wrb_en === 1'b1) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_write addr=%0d data=%0h sel=%0h, no write expected",
                 wrb_addr, wrb_data, wrb_sel);
      end else begin
        eb = qb.pop_front();
        chk("b_beat", 64'({wrb_addr, wrb_data, wrb_sel}), 64'({eb.addr, eb.data, eb.sel}));
        seen0_b[wrb_addr] = seen0_b[wrb_addr] | wrb_data[0];
        seen1_b[wrb_addr] = seen1_b[wrb_addr] | wrb_data[1];
      end
    end
  end

  localparam logic [63:0] EN_ONE  = (64'd1 << 33) - 64'd2;  // cycles 1..32
  localparam logic [63:0] BLK_ONE = (64'd1 << 34) - 64'd2;  // cycles 1..33
  localparam logic [63:0] RDY_ONE = ((64'd1 << 37) - 64'd1) ^ ((64'd1 << 34) - 64'd1);

  logic [63:0] en_v, blk_v, rdy_v;

  initial begin
    rst = 1'b1;
    if_a.s_valid = 1'b0; if_a.s_idx = '0; if_a.s_key = '0; if_a.s_mask = '0; if_a.s_del = 1'b0;
    if_b.s_valid = 1'b0; if_b.s_idx = '0; if_b.s_key = '0; if_b.s_mask = '0; if_b.s_del = 1'b0;
    seen0_a = '0; seen1_a = '0; seen0_b = '0; seen1_b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("a_rst_ready", 64'(if_a.s_ready), 64'd1);
    chk("a_rst_wr", 64'({wra_en, wra_addr, wra_data, wra_sel}), 64'd0);
    chk("a_rst_blk_err", 64'({blk_a, err_a}), 64'd0);
    chk("b_rst_ready", 64'(if_b.s_ready), 64'd1);
    chk("b_rst_wr", 64'({wrb_en, wrb_addr, wrb_data, wrb_sel}), 64'd0);

    // Full-care write: slice0 = 21, slice1 = 10.
    seen0_a = '0; seen1_a = '0;
    send_a(4'd3, 10'h155, 10'h3FF, 1'b0);
    if_a.s_valid = 1'b0;
    observe_a(36, en_v, blk_v, rdy_v);
    chk("w1_wr_en_window", en_v, EN_ONE);
    chk("w1_block_window", blk_v, BLK_ONE);
    chk("w1_ready_window", rdy_v, RDY_ONE);
    chk("w1_queue_empty", 64'(qa.size()), 64'd0);
    chk("w1_slice0_hits", 64'(seen0_a), 64'h0020_0000);
    chk("w1_slice1_hits", 64'(seen1_a), 64'h0000_0400);

    // All don't-care.
    seen0_a = '0; seen1_a = '0;
    send_a(4'd1, 10'h2AB, 10'h000, 1'b0);
    if_a.s_valid = 1'b0;
    wait_idle_a(60);
    chk("dc_queue_empty", 64'(qa.size()), 64'd0);
    chk("dc_hits", 64'({seen1_a, seen0_a}), 64'hFFFF_FFFF_FFFF_FFFF);

    // Delete.
    seen0_a = '0; seen1_a = '0;
    send_a(4'd5, 10'h3FF, 10'h000, 1'b1);
    if_a.s_valid = 1'b0;
    wait_idle_a(60);
    chk("del_queue_empty", 64'(qa.size()), 64'd0);
    chk("del_hits", 64'({seen1_a, seen0_a}), 64'd0);

    // Padded 7-bit instance.
    seen0_b = '0; seen1_b = '0;
    push(1'b1, 7, 4'd2, 10'h07F, 10'h07F, 1'b0);
    if_b.s_idx = 4'd2; if_b.s_key = 7'h7F; if_b.s_mask = 7'h7F; if_b.s_del = 1'b0;
    if_b.s_valid = 1'b1;
    @(posedge clk);
    #1;
    if_b.s_valid = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
    end
    chk("pad_ready", 64'(if_b.s_ready), 64'd1);
    chk("pad_queue_empty", 64'(qb.size()), 64'd0);
    chk("pad_slice0_hits", 64'(seen0_b), 64'h8000_0000);
    chk("pad_slice1_hits", 64'(seen1_b), 64'h8888_8888);

    // Out-of-range index.
    send_a(4'd9, 10'h155, 10'h3FF, 1'b0);
    if_a.s_valid = 1'b0;
    chk("bad_err_pulse", 64'(err_a), 64'd1);
    observe_a(5, en_v, blk_v, rdy_v);
    chk("bad_no_write", en_v, 64'd0);
    chk("bad_ready_held", rdy_v, (64'd1 << 6) - 64'd2);
    chk("bad_err_drops", 64'(err_a), 64'd0);

    // Back-to-back with valid held: second handshake in cycle T+34.
    seen0_a = '0; seen1_a = '0;
    send_a(4'd0, 10'h000, 10'h3FF, 1'b0);
    if_a.s_idx = 4'd7; if_a.s_key = 10'h3FF; if_a.s_mask = 10'h3FF; if_a.s_del = 1'b0;
    push(1'b0, 10, 4'd7, 10'h3FF, 10'h3FF, 1'b0);
    observe_a(36, en_v, blk_v, rdy_v);
    if_a.s_valid = 1'b0;
    chk("b2b_wr_en_window", en_v, EN_ONE | (64'd3 << 35));
    chk("b2b_block_window", blk_v, BLK_ONE | (64'd3 << 35));
    chk("b2b_ready_window", rdy_v, 64'd1 << 34);
    wait_idle_a(60);
    chk("b2b_queue_empty", 64'(qa.size()), 64'd0);
    chk("b2b_hits", 64'({seen1_a, seen0_a}), 64'h8000_0001_8000_0001);

    // Reset while writing address 12.
    send_a(4'd2, 10'h0F0, 10'h3FF, 1'b0);
    if_a.s_valid = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    chk("rst_at_addr12", 64'({wra_en, wra_addr}), 64'({1'b1, 5'd12}));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_wr_en", 64'(wra_en), 64'd0);
    chk("rst_mid_ready", 64'(if_a.s_ready), 64'd1);
    chk("rst_mid_block_addr", 64'({blk_a, wra_addr}), 64'd0);
    chk("rst_mid_leftover", 64'(qa.size()), 64'd19);
    qa.delete();
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
